// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: entry layout
// carried through the prefetch buffer and the in-flight PC queue.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               exc;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_CLEAR = '{pc: {PC_W{1'b0}}, instr: NOP_INSTR, exc: 1'b0};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, occupancy count and full/empty.
// A push in the flush cycle lands as the sole entry of the emptied FIFO.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_r [DEPTH];
  logic [IDX_W-1:0] wr_ptr_r;
  logic [IDX_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(DEPTH - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1'b1);
    end
  endfunction

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify push/pop against occupancy; flush always makes room for a push.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = push;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= ENTRY_CLEAR;
      end
      wr_ptr_r <= {IDX_W{1'b0}};
      rd_ptr_r <= {IDX_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {IDX_W{1'b0}};
      if (do_push_s) begin
        mem_r[0] <= push_data;
        wr_ptr_r <= next_idx({IDX_W{1'b0}});
        count_r  <= CNT_W'(1'b1);
      end else begin
        wr_ptr_r <= {IDX_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_idx(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_idx(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// RV32I fetch stage with prefetch buffer, credit-limited pipelined imem requests
// and redirect handling. FETCH_ALIGN_EXC_EN enables the misaligned-target trap.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_ALIGN_EXC_EN
  ,
  output logic               if_exc
`endif
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BUF_CW = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W  = BUF_CW + 1;

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [OUT_W-1:0]  drop_cnt_r;
  logic              started_r;
  logic [OUT_W-1:0]  outstanding_s;
  logic [OUT_W-1:0]  out_after_resp_s;
  logic [ADDR_W-1:0] target_pc_s;
  logic              misaligned_s;
  logic              halted_s;
  logic              req_s;
  logic              grant_s;
  logic              resp_s;
  logic              keep_resp_s;
  logic              exc_push_s;
  logic              buf_push_s;
  logic              buf_pop_s;
  logic              buf_full_s;
  logic              buf_empty_s;
  logic [BUF_CW-1:0] buf_count_s;
  logic              ifq_full_s;
  logic              ifq_empty_s;
  fetch_entry_t      buf_push_data_s;
  fetch_entry_t      buf_head_s;
  fetch_entry_t      ifq_push_data_s;
  fetch_entry_t      ifq_head_s;
  logic              unused_s;

`ifdef FETCH_ALIGN_EXC_EN
  logic halted_r;

  assign target_pc_s  = redirect_pc;
  assign misaligned_s = (redirect_pc[1:0] != 2'b00);
  assign halted_s     = halted_r;

  // Halt on a misaligned redirect target; only a later redirect resumes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      halted_r <= misaligned_s;
    end else begin
      halted_r <= halted_r;
    end
  end
`else
  assign target_pc_s  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign misaligned_s = 1'b0;
  assign halted_s     = 1'b0;
`endif

  // A response can only be honoured while a request is really in flight.
  assign resp_s           = imem_rvalid && !ifq_empty_s;
  assign out_after_resp_s = outstanding_s - OUT_W'(resp_s);
  assign keep_resp_s      = resp_s && (drop_cnt_r == {OUT_W{1'b0}}) && !redirect_valid;
  assign exc_push_s       = redirect_valid && misaligned_s;
  assign buf_push_s       = keep_resp_s || exc_push_s;
  assign buf_pop_s        = if_valid && if_ready && !redirect_valid;
  assign grant_s          = req_s && imem_gnt;

  // Credit check: in-flight plus buffered entries must never exceed the buffer.
  always_comb begin
    req_s = 1'b0;
    if (started_r && !redirect_valid && !halted_s &&
        (outstanding_s < OUT_W'(MAX_OUTSTANDING)) &&
        ((SUM_W'(outstanding_s) + SUM_W'(buf_count_s)) < SUM_W'(DEPTH))) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Select what enters the prefetch buffer: trap marker or returned instruction.
  always_comb begin
    buf_push_data_s = ENTRY_CLEAR;
    if (exc_push_s) begin
      buf_push_data_s.pc    = PC_W'(target_pc_s);
      buf_push_data_s.instr = NOP_INSTR;
      buf_push_data_s.exc   = 1'b1;
    end else begin
      buf_push_data_s.pc    = ifq_head_s.pc;
      buf_push_data_s.instr = imem_rdata;
      buf_push_data_s.exc   = 1'b0;
    end
  end

  // Request PC recorded alongside each grant.
  always_comb begin
    ifq_push_data_s    = ENTRY_CLEAR;
    ifq_push_data_s.pc = PC_W'(fetch_pc_r);
  end

  // Fetch PC, drop counter and post-reset request enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_r  <= 1'b0;
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= {OUT_W{1'b0}};
    end else begin
      started_r <= 1'b1;
      if (redirect_valid) begin
        fetch_pc_r <= target_pc_s;
        drop_cnt_r <= out_after_resp_s;
      end else begin
        if (grant_s) begin
          fetch_pc_r <= fetch_pc_r + ADDR_W'(32'd4);
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (resp_s && (drop_cnt_r != {OUT_W{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - OUT_W'(1'b1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_prefetch_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (buf_push_s),
    .push_data (buf_push_data_s),
    .pop       (buf_pop_s),
    .head      (buf_head_s),
    .count     (buf_count_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s)
  );

  // In-flight queue is never flushed: stale responses still pop their PCs.
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_inflight_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (1'b0),
    .push      (grant_s),
    .push_data (ifq_push_data_s),
    .pop       (resp_s),
    .head      (ifq_head_s),
    .count     (outstanding_s),
    .full      (ifq_full_s),
    .empty     (ifq_empty_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;

  // Present the buffer head to decode; idle values when empty.
  always_comb begin
    if_valid = 1'b0;
    if_instr = NOP_INSTR;
    if_pc    = {ADDR_W{1'b0}};
    if (!buf_empty_s) begin
      if_valid = 1'b1;
      if_instr = buf_head_s.instr;
      if_pc    = ADDR_W'(buf_head_s.pc);
    end else begin
      if_valid = 1'b0;
      if_instr = NOP_INSTR;
      if_pc    = {ADDR_W{1'b0}};
    end
  end

`ifdef FETCH_ALIGN_EXC_EN
  assign if_exc = if_valid && buf_head_s.exc;
`endif

  assign unused_s = ^{ifq_head_s.instr, ifq_head_s.exc, ifq_full_s, buf_full_s,
                      buf_head_s.exc, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch against a queue-based reference model.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          DEP  = 4;
  localparam int          MAXO = 2;
  localparam logic [31:0] RPC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_ALIGN_EXC_EN
  logic        if_exc;
`endif

  always #5 clk = ~clk;

  fetch_prefetch #(.ADDR_W(32), .DEPTH(DEP), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_ALIGN_EXC_EN
    , .if_exc(if_exc)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          exc;
  } ent_t;

  // Reference model state
  ent_t        buf_q[$];
  logic [31:0] infl_q[$];
  int          drop;
  logic [31:0] fpc;
  bit          started;
  bit          halted;
  // Memory model: granted addresses and the earliest cycle each may return
  logic [31:0] mem_a[$];
  int          mem_t[$];

  int cyc, total, bad;
  bit gnt_rand, rv_rand, redir_req;
  int lat_min, lat_max, rdy_mode;
  logic [31:0] redir_pc_req;
  logic obs_req, obs_valid, obs_exc;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    imem_rvalid = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
    buf_q.delete(); infl_q.delete(); mem_a.delete(); mem_t.delete();
    drop = 0; halted = 1'b0; started = 1'b0; fpc = RPC;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_ALIGN_EXC_EN
    chk("rst_if_exc", 32'(if_exc), 32'h0);
`endif
    repeat (n) @(posedge clk);
    cyc += n;
    #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, compare DUT with model, then advance the model.
  task automatic step();
    bit resp, grant, pop, redir, exp_req, exp_valid, exp_exc;
    logic [31:0] rdata, rpc, ppc, exp_pc, exp_instr;
    int lat;
    imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    redir = redir_req;
    rpc = redir_pc_req;
    redirect_valid = redir;
    redirect_pc = rpc;
    resp = (mem_a.size() > 0) && (mem_t[0] <= cyc) && (!rv_rand || $urandom_range(0, 3) != 0);
    rdata = resp ? instr_of(mem_a[0]) : $urandom;
    imem_rvalid = resp;
    imem_rdata = rdata;
    #1;
    exp_req = started && !redir && !halted && (infl_q.size() < MAXO) &&
              (infl_q.size() + buf_q.size() < DEP);
    exp_valid = (buf_q.size() > 0);
    exp_pc = exp_valid ? buf_q[0].pc : 32'h0;
    exp_instr = exp_valid ? buf_q[0].instr : 32'h0000_0013;
    exp_exc = exp_valid ? buf_q[0].exc : 1'b0;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = if_valid;
    obs_pc = if_pc; obs_instr = if_instr; obs_exc = 1'b0;
`ifdef FETCH_ALIGN_EXC_EN
    obs_exc = if_exc;
    chk("if_exc", 32'(if_exc), 32'(exp_exc));
`endif
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, fpc);
    chk("if_valid", 32'(if_valid), 32'(exp_valid));
    chk("if_pc", if_pc, exp_pc);
    chk("if_instr", if_instr, exp_instr);
    grant = exp_req && imem_gnt;
    pop = exp_valid && if_ready;
    if (grant) begin
      lat = $urandom_range(lat_min, lat_max);
      mem_a.push_back(fpc);
      mem_t.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    started = 1'b1;
    if (pop && !redir) void'(buf_q.pop_front());
    ppc = 32'h0;
    if (resp) begin
      ppc = infl_q.pop_front();
      void'(mem_a.pop_front());
      void'(mem_t.pop_front());
    end
    if (redir) begin
      buf_q.delete();
      drop = infl_q.size();
      halted = 1'b0;
`ifdef FETCH_ALIGN_EXC_EN
      fpc = rpc;
      if (rpc[1:0] != 2'b00) begin
        halted = 1'b1;
        buf_q.push_back('{pc: rpc, instr: 32'h0000_0013, exc: 1'b1});
      end
`else
      fpc = rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (resp) begin
        if (drop == 0) buf_q.push_back('{pc: ppc, instr: rdata, exc: 1'b0});
        else drop--;
      end
      if (grant) begin
        infl_q.push_back(fpc);
        fpc = fpc + 32'd4;
      end
    end
    redir_req = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0;
    gnt_rand = 1'b0; rv_rand = 1'b0; redir_req = 1'b0; redir_pc_req = 32'h0;
    lat_min = 1; lat_max = 1; rdy_mode = 1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Back-to-back streaming from RESET_PC
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_valid", 32'(obs_valid), 32'h1);
      chk("seq_pc", obs_pc, RPC + 32'(4 * k));
      chk("seq_req", 32'(obs_req), 32'h1);
    end

    // Decode stall fills the buffer and blocks requests
    rdy_mode = 0;
    repeat (8) step();
    chk("full_req", 32'(obs_req), 32'h0);
    chk("full_head_pc", obs_pc, 32'h0000_010C);
    rdy_mode = 1;
    repeat (2) step();
    chk("drain_req", 32'(obs_req), 32'h1);
    chk("drain_head_pc", obs_pc, 32'h0000_0110);

    // Redirect with responses in flight
    lat_min = 3; lat_max = 3;
    repeat (4) step();
    redir_req = 1'b1; redir_pc_req = 32'h0000_0200;
    step();
    n = 0;
    do begin step(); n++; end while (!obs_valid && n < 20);
    chk("redir_timeout", 32'(n < 20), 32'h1);
    chk("redir_first_pc", obs_pc, 32'h0000_0200);

    // Address wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    redir_req = 1'b1; redir_pc_req = 32'hFFFF_FFFC;
    step();
    n = 0;
    do begin step(); n++; end while (!obs_req && n < 10);
    chk("wrap_addr_hi", obs_addr, 32'hFFFF_FFFC);
    n = 0;
    do begin step(); n++; end while (!obs_req && n < 10);
    chk("wrap_addr_lo", obs_addr, 32'h0000_0000);

`ifdef FETCH_ALIGN_EXC_EN
    redir_req = 1'b1; redir_pc_req = 32'h0000_0202;
    step();
    step();
    chk("exc_valid", 32'(obs_valid), 32'h1);
    chk("exc_flag", 32'(obs_exc), 32'h1);
    chk("exc_pc", obs_pc, 32'h0000_0202);
    chk("exc_instr", obs_instr, 32'h0000_0013);
    repeat (5) begin
      step();
      chk("exc_no_req", 32'(obs_req), 32'h0);
    end
    redir_req = 1'b1; redir_pc_req = 32'h0000_0300;
    step();
    step();
    chk("exc_resume_req", 32'(obs_req), 32'h1);
    chk("exc_resume_addr", obs_addr, 32'h0000_0300);
`endif

    // Randomized traffic, redirects and a mid-run reset
    gnt_rand = 1'b1; rv_rand = 1'b1; lat_min = 1; lat_max = 4; rdy_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(2);
      if ($urandom_range(0, 24) == 0) begin
        redir_req = 1'b1;
        case ($urandom_range(0, 3))
          0: redir_pc_req = 32'hFFFF_FFF4;
          1: redir_pc_req = $urandom;
          default: redir_pc_req = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
